spi_cfg_responder: RTL and testbench
====================================

# spi_cfg_responder

SPI mode-0 slave that responds to the PLL configuration SPI master. It receives a DATA_WIDTH-bit word on mosi and, in the same frame, shifts a readback word out on miso. It sits on the PLL IP's config path, fully inside the system `clk` domain. sclk, ss_n and mosi are treated as asynchronous pins and oversampled.

## Interface
- DATA_WIDTH, 512: bits per frame; MSB first in both directions.
- SYNC_STAGES, 2: synchronizer flops on sclk, ss_n and mosi (≥2).
- clk  input  1  system clock (50 MHz nominal).
- rst  input  1  reset; asynchronous and active-high.
- sclk  input  1  SPI clock from master; CPOL=0, idles low.
- ss_n  input  1  active-low frame select.
- mosi  input  1  serial data in; sampled on sclk rising.
- tx_data_i  input  DATA_WIDTH  readback word; captured when a frame starts.
- miso  output  1  serial data out; updated on sclk falling; 0 when not selected.
- rx_data_o  output  DATA_WIDTH  last complete received word; holds between frames.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o is updated.
- frame_err_o  output  1  one-cycle pulse when a frame ends with bit count ≠ DATA_WIDTH.
- busy_o  output  1  high while a frame is active.

## Operation
- The sclk, ss_n and mosi inputs each pass through a SYNC_STAGES flop chain. One extra history flop on sclk and ss_n provides edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.
- The FSM has two states, IDLE and ACTIVE.
- IDLE → ACTIVE on ss_fall:
  - tx_shift ← tx_data_i.
  - miso ← tx_data_i[DATA_WIDTH-1]; the MSB is presented before the first sclk rise (CPHA=0).
  - bit_cnt ← 0.
- In ACTIVE on sclk_rise:
  - rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi_sync}.
  - bit_cnt increments and saturates at DATA_WIDTH+1; reaching DATA_WIDTH+1 marks overrun.
- In ACTIVE on sclk_fall: tx_shift shifts left and miso ← the next bit. After DATA_WIDTH bits, miso = 0.
- ACTIVE → IDLE on ss_rise:
  - If bit_cnt == DATA_WIDTH: rx_data_o ← rx_shift and rx_valid_o pulses.
  - Otherwise frame_err_o pulses and rx_data_o is unchanged.
  - miso ← 0.
- sclk edges are ignored while in IDLE.
- If ss_rise and an sclk edge land in the same cycle, the ss_rise wins and the sclk edge is dropped.
- bit_cnt width is $clog2(DATA_WIDTH+2).
- rx_valid_o and frame_err_o are never high together.

## Timing
- Reset values: miso=0, rx_data_o=0, rx_valid_o=0, frame_err_o=0, busy_o=0, state=IDLE. All shift registers and bit_cnt are 0.
- Reset asserted mid-frame aborts the frame with no rx_valid/frame_err pulse. The rest of that frame is ignored until the next ss_fall seen from IDLE.
- Pin-to-edge-detect latency is SYNC_STAGES+1 clk.
- miso is registered and changes 1 clk after the detected edge, i.e. SYNC_STAGES+2 clk after the pin edge.
- rx_valid_o / frame_err_o assert SYNC_STAGES+2 clk after the ss_n rising pin edge and last one cycle.
- busy_o goes high the cycle after ss_fall and low the cycle after ss_rise.
- Constraints:
  - sclk high and low times must each be ≥ SYNC_STAGES+3 clk (5 clk at default); 50/5 MHz meets this.
  - ss_n must stay high ≥ SYNC_STAGES+2 clk between frames.
  - Master setup on mosi must be ≥ 1 clk before sclk rise.
- tx_data_i only needs to be stable in the cycle ss_fall is detected.

## Structure
- Package spi_cfg_pkg holds:
  - the state typedef (IDLE, ACTIVE);
  - localparam DEFAULT_DATA_WIDTH = 512;
  - DEFAULT_SYNC_STAGES = 2.
- Sub-module sync_edge_det (parameter SYNC_STAGES) contains the synchronizer chain plus rise/fall outputs. It is instantiated for sclk and ss_n.
- mosi uses the same sync_edge_det with its edge outputs unused.
- Top level contains the FSM, bit counter, and the two shift registers.

## Test plan
- Bench uses DATA_WIDTH=8, 50 MHz clk, 5 MHz sclk.
- Reset: assert rst with ss_n low and sclk toggling → miso=0, rx_data_o=0x00, rx_valid_o=0, frame_err_o=0, busy_o=0.
- Full frame: mosi 0x35, tx_data_i=0xA5 → master samples miso 1,0,1,0,0,1,0,1. rx_data_o=0x35 with a single rx_valid_o pulse 4 clk after the ss_n rising edge.
- Short frame: 5 sclk pulses then ss_n rises → frame_err_o pulses once, rx_valid_o stays 0, rx_data_o remains 0x35.
- Long frame: 9 sclk pulses with mosi 0xFF then 1 → frame_err_o pulses once, rx_data_o remains 0x35.
- Reset mid-frame: assert rst after 3 bits, then release; next full frame mosi 0x44 → rx_data_o=0x44, exactly one rx_valid_o pulse, no frame_err_o.
- Back-to-back frames: ss_n high 4 clk between frames; tx_data_i changes 0xA5 → 0x3C between frames; mosi 0x12 then 0x34 → second miso sequence is 0x3C; two rx_valid_o pulses with rx_data_o=0x12 then 0x34.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types and defaults for the PLL config SPI responder
package spi_cfg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 512;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - pin synchronizer with registered rise/fall pulses
module sync_edge_det
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_last;

  assign w_last = r_chain[SYNC_STAGES-1];

  // Edge pulses are registered so the consumer sees them SYNC_STAGES+1 clk after the pin moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
      r_hist  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
      r_hist  <= w_last;
      r_rise  <= w_last & ~r_hist;
      r_fall  <= ~w_last & r_hist;
    end
  end

  assign o_sync = w_last;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_cfg_responder.sv
// rtl/spi_cfg_responder.sv - SPI mode-0 slave returning a readback word while receiving a config word
module spi_cfg_responder
  import spi_cfg_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH + 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_sync_unused;
  logic w_ss_rise, w_ss_fall, w_ss_sync_unused;
  logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (sclk),
    .o_sync (w_sclk_sync_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (ss_n),
    .o_sync (w_ss_sync_unused),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (mosi),
    .o_sync (w_mosi_sync),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  state_t                r_state, w_state_next;
  logic                  w_start, w_end, w_sample, w_shift;
  // The MSB goes straight to miso at frame start, so only the remaining bits are held here
  logic [DATA_WIDTH-2:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_miso, r_rx_valid, r_frame_err;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_start      = 1'b1;
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Frame end takes priority; an sclk edge in the same cycle is dropped
        if (w_ss_rise) begin
          w_end        = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_sample = w_sclk_rise;
          w_shift  = w_sclk_fall;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_tx_shift <= tx_data_i[DATA_WIDTH-2:0];
        r_miso     <= tx_data_i[DATA_WIDTH-1];
        r_bit_cnt  <= '0;
      end
      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_sync};
        if (r_bit_cnt != CNT_MAX) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
      // Zero fill means miso naturally drops to 0 once every data bit has gone out
      if (w_shift) begin
        r_miso     <= r_tx_shift[DATA_WIDTH-2];
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-3:0], 1'b0};
      end
      if (w_end) begin
        r_miso <= 1'b0;
        if (r_bit_cnt == CNT_FULL) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign miso        = r_miso;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign frame_err_o = r_frame_err;
  assign busy_o      = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_cfg_responder.sv
// tb/tb_spi_cfg_responder.sv - randomized self-checking bench for spi_cfg_responder
module tb_spi_cfg_responder;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic [DW-1:0] tx_data_i;
  logic          miso;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          frame_err_o;
  logic          busy_o;

  spi_cfg_responder #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .tx_data_i   (tx_data_i),
    .miso        (miso),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int          at;
  } evt_t;

  evt_t       obs_q[$];
  evt_t       exp_q[$];
  logic [7:0] rx_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid_o || frame_err_o) begin
      check("pulse_exclusive", {31'b0, rx_valid_o & frame_err_o}, 32'd0);
      obs_q.push_back('{frame_err_o, rx_data_o, cyc});
    end
  end

  // One frame from the master's side; rst_at >= 0 pulses reset before that bit index
  task automatic run_frame(input int nbits, input logic [7:0] tx, input logic [15:0] mbits,
                           input int rst_at, input int gap);
    logic aborted;
    logic exp_bit;
    int   c;
    aborted   = 1'b0;
    tx_data_i = tx;
    ss_n      = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        aborted  = 1'b1;
        rx_model = 8'h00;
      end
      mosi = mbits[nbits-1-i];
      repeat (5) @(negedge clk);
      exp_bit = 1'b0;
      if (!aborted && i < DW) exp_bit = tx[DW-1-i];
      check("miso_bit", {31'b0, miso}, {31'b0, exp_bit});
      check("busy_in_frame", {31'b0, busy_o}, {31'b0, !aborted});
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    c    = cyc;
    if (!aborted) begin
      if (nbits == DW) begin
        rx_model = mbits[7:0];
        exp_q.push_back('{1'b0, rx_model, c + 4});
      end else begin
        exp_q.push_back('{1'b1, rx_model, c + 4});
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    evt_t e;
    evt_t o;
    repeat (10) @(negedge clk);
    check("event_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("event_kind", {31'b0, o.is_err}, {31'b0, e.is_err});
      check("event_data", {24'b0, o.data}, {24'b0, e.data});
      check("event_cycle", o.at, e.at);
    end
    exp_q.delete();
    obs_q.delete();
    check("rx_data_hold", {24'b0, rx_data_o}, {24'b0, rx_model});
    check("miso_idle", {31'b0, miso}, 32'd0);
    check("busy_idle", {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] tx;
    logic [15:0] m;
    int         gap;

    rst       = 1'b1;
    ss_n      = 1'b0;
    sclk      = 1'b0;
    mosi      = 1'b0;
    tx_data_i = 8'h00;
    rx_model  = 8'h00;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge clk);
      sclk = ~sclk;
    end
    check("rst_miso", {31'b0, miso}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data_o}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid_o}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    sclk = 1'b0;
    rst  = 1'b0;
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    drain();

    run_frame(8, 8'hA5, 16'h0035, -1, 10);
    drain();
    run_frame(5, 8'hA5, 16'h001B, -1, 10);
    drain();
    run_frame(9, 8'hA5, 16'h01FF, -1, 10);
    drain();
    run_frame(8, 8'hA5, 16'h005A, 3, 10);
    drain();
    run_frame(8, 8'h96, 16'h0044, -1, 10);
    drain();
    run_frame(8, 8'hA5, 16'h0012, -1, 4);
    run_frame(8, 8'h3C, 16'h0034, -1, 4);
    drain();

    for (int k = 0; k < 20; k++) begin
      n   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : 8;
      tx  = 8'($urandom);
      m   = 16'($urandom);
      gap = int'($urandom_range(4, 12));
      run_frame(n, tx, m, -1, gap);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
